// File: rtl/trace_pkg.sv
// Shared types for the CPU trace buffer.
//   trace_state_e : capture/readout state, visible on the top-level state output
//   trace_mode_e  : capture mode, sampled when arm is pulsed
//   trace_entry_t : layout of one packed CPU snapshot (246 bits)
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_TRIG = 1'b1
  } trace_mode_e;

  typedef struct packed {
    logic [37:0]      ctrl;       // relay control lines
    logic [2:0]       alu_code;
    logic [4:0]       fsm_state;
    logic [7:0]       inst;
    logic [7:0]       data_bus;
    logic [15:0]      addr_bus;
    logic [15:0]      pc;
    logic [15:0]      inc;        // address incrementer latch
    logic [16:0][7:0] regs;       // 8-bit register file snapshot
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_ring_mem.sv
// Ring storage for the trace buffer: DEPTH x ENTRY_W flop array.
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read data, mem[raddr]
// No reset: contents are only meaningful where the buffer's count says so.
module trace_ring_mem #(
  parameter int ENTRY_W = 246,
  parameter int DEPTH   = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Capture buffer for relay-computer debug snapshots.
// Records one entry per cap_valid cycle into a DEPTH-deep ring, then replays
// oldest-first over a valid/ready port. Never back-pressures the core.
//   clock, reset              : system clock, async active-high reset
//   arm, mode, post_count     : start a capture (mode/post_count sampled on arm)
//   trig_pc_en, trig_pc       : optional PC-match trigger
//   stop                      : force end of capture
//   cap_valid/entry/pc/halt   : snapshot input
//   rd_valid/ready/entry/last : replay port
//   state, count, triggered   : status
//
// state | meaning
// IDLE  | nothing captured, waiting for arm
// ARMED | capturing; FILL stops when full, TRIG waits for trigger
// POST  | trigger seen, capturing the remaining post-trigger entries
// DONE  | capture finished, replaying entries oldest-first
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int ENTRY_W = 246,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 16,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic               mode,
  input  logic [CNT_W-1:0]   post_count,
  input  logic               trig_pc_en,
  input  logic [ADDR_W-1:0]  trig_pc,
  input  logic               stop,
  input  logic               cap_valid,
  input  logic [ENTRY_W-1:0] cap_entry,
  input  logic [ADDR_W-1:0]  cap_pc,
  input  logic               cap_halt,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   count,
  output logic               triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

  trace_state_e     state_q, state_n;
  trace_mode_e      mode_q, mode_n;
  logic [AW-1:0]    wptr_q, wptr_n, rptr_q, rptr_n;
  logic [CNT_W-1:0] count_q, count_n, remain_q, remain_n, post_q, post_n;
  logic             trig_q, trig_n, rd_valid_q, rd_valid_n;
  logic             we, hit;

  assign hit = cap_valid & (cap_halt | (trig_pc_en & (cap_pc == trig_pc)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_FILL;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      remain_q   <= '0;
      post_q     <= '0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      wptr_q     <= wptr_n;
      rptr_q     <= rptr_n;
      count_q    <= count_n;
      remain_q   <= remain_n;
      post_q     <= post_n;
      trig_q     <= trig_n;
      rd_valid_q <= rd_valid_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    mode_n     = mode_q;
    wptr_n     = wptr_q;
    rptr_n     = rptr_q;
    count_n    = count_q;
    remain_n   = remain_q;
    post_n     = post_q;
    trig_n     = trig_q;
    rd_valid_n = rd_valid_q;
    we         = 1'b0;

    if (arm) begin
      state_n    = ARMED;
      mode_n     = trace_mode_e'(mode);
      post_n     = (post_count > FULL_M1) ? FULL_M1 : post_count;
      wptr_n     = '0;
      rptr_n     = '0;
      count_n    = '0;
      remain_n   = '0;
      trig_n     = 1'b0;
      rd_valid_n = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED, POST: begin
          if (cap_valid) begin
            we      = 1'b1;
            wptr_n  = wptr_q + PTR_ONE;
            count_n = (count_q == FULL) ? FULL : count_q + CNT_ONE;
            if (state_q == ARMED) begin
              if (mode_q == MODE_FILL) begin
                if (count_q == FULL_M1) state_n = DONE;
              end else if (hit) begin
                trig_n   = 1'b1;
                remain_n = post_q;
                state_n  = (post_q == '0) ? DONE : POST;
              end
            end else begin
              remain_n = remain_q - CNT_ONE;
              if (remain_q == CNT_ONE) state_n = DONE;
            end
          end
          if (stop) state_n = DONE;
        end
        DONE: begin
          // First DONE cycle positions rptr at the oldest entry; a full
          // ring has wrapped, so the oldest sits at the write pointer.
          if (!rd_valid_q) begin
            if (count_q == '0) begin
              state_n = IDLE;
            end else begin
              rd_valid_n = 1'b1;
              rptr_n     = (count_q == FULL) ? wptr_q : '0;
            end
          end else if (rd_ready) begin
            rptr_n  = rptr_q + PTR_ONE;
            count_n = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
              rd_valid_n = 1'b0;
              state_n    = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  trace_ring_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (we),
    .waddr (wptr_q),
    .wdata (cap_entry),
    .raddr (rptr_q),
    .rdata (rd_entry)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_valid_q & (count_q == CNT_ONE);
  assign state     = state_q;
  assign count     = count_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with a 4-entry ring.
module tb_cpu_trace_buffer;

  localparam int ENTRY_W = 246;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               arm = 1'b0, mode = 1'b0, stop = 1'b0;
  logic [CNT_W-1:0]   post_count = '0;
  logic               trig_pc_en = 1'b0;
  logic [ADDR_W-1:0]  trig_pc = '0;
  logic               cap_valid = 1'b0, cap_halt = 1'b0;
  logic [ENTRY_W-1:0] cap_entry = '0;
  logic [ADDR_W-1:0]  cap_pc = '0;
  logic               rd_valid, rd_ready = 1'b0, rd_last, triggered;
  logic [ENTRY_W-1:0] rd_entry;
  logic [1:0]         state;
  logic [CNT_W-1:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_trace_buffer #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .arm(arm), .mode(mode), .post_count(post_count),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .stop(stop), .cap_valid(cap_valid),
    .cap_entry(cap_entry), .cap_pc(cap_pc), .cap_halt(cap_halt), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_entry(rd_entry), .rd_last(rd_last), .state(state),
    .count(count), .triggered(triggered)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic [CNT_W-1:0] pc);
    arm = 1'b1; mode = m; post_count = pc;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    int w = 0;
    while (rd_valid !== 1'b1 && w < 10) begin tick(); w++; end
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL %s_rd_valid_timeout got=%b exp=1", tag, rd_valid); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if (state !== S_IDLE || count !== '0 || triggered !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs state=%0d count=%0d trig=%b rdv=%b last=%b exp 0/0/0/0/0",
               state, count, triggered, rd_valid, rd_last);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill;
    // cap_valid on the arm cycle must be dropped
    cap_valid = 1'b1; cap_entry = ENTRY_W'(8'hFF);
    do_arm(1'b0, '0);
    cap_valid = 1'b0;
    n_checks++;
    if (state !== S_ARMED || count !== '0) begin
      n_fail++; $display("FAIL fill_armed state=%0d count=%0d exp state=1 count=0", state, count);
    end
    for (int i = 1; i <= 6; i++) begin
      cap_valid = 1'b1; cap_entry = ENTRY_W'(i);
      tick();
      if (i == 3) begin
        n_checks++;
        if (state !== S_ARMED || count !== CNT_W'(3)) begin
          n_fail++; $display("FAIL fill_third state=%0d count=%0d exp state=1 count=3", state, count);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (state !== S_DONE || count !== CNT_W'(4) || rd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_done state=%0d count=%0d rdv=%b exp state=3 count=4 rdv=0", state, count, rd_valid);
        end
      end
    end
    cap_valid = 1'b0;
    wait_rd("fill");
    rd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_entry !== ENTRY_W'(k) || rd_last !== (k == 4)) begin
        n_fail++;
        $display("FAIL fill_read%0d entry=%0h valid=%b last=%b exp entry=%0h valid=1 last=%b",
                 k, rd_entry, rd_valid, rd_last, k, (k == 4));
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (state !== S_IDLE || count !== '0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_idle state=%0d count=%0d rdv=%b exp 0/0/0", state, count, rd_valid);
    end
  endtask

  task automatic test_trig_pc;
    trig_pc_en = 1'b1; trig_pc = 16'h0100;
    do_arm(1'b1, CNT_W'(2));
    for (int i = 1; i <= 9; i++) begin
      cap_valid = 1'b1; cap_entry = ENTRY_W'(i);
      cap_pc = (i == 6) ? 16'h0100 : ADDR_W'(i);
      tick();
      if (i == 5) begin
        n_checks++;
        if (state !== S_ARMED || triggered !== 1'b0 || count !== CNT_W'(4)) begin
          n_fail++;
          $display("FAIL trig_pre state=%0d trig=%b count=%0d exp state=1 trig=0 count=4", state, triggered, count);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (state !== S_POST || triggered !== 1'b1) begin
          n_fail++; $display("FAIL trig_hit state=%0d trig=%b exp state=2 trig=1", state, triggered);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (state !== S_POST) begin n_fail++; $display("FAIL trig_post1 state=%0d exp=2", state); end
      end
      if (i == 8) begin
        n_checks++;
        if (state !== S_DONE || count !== CNT_W'(4)) begin
          n_fail++; $display("FAIL trig_done state=%0d count=%0d exp state=3 count=4", state, count);
        end
      end
    end
    cap_valid = 1'b0; trig_pc_en = 1'b0; cap_pc = '0;
    wait_rd("trig");
    rd_ready = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_entry !== ENTRY_W'(k) || rd_last !== (k == 8)) begin
        n_fail++;
        $display("FAIL trig_read%0d entry=%0h valid=%b last=%b exp entry=%0h valid=1 last=%b",
                 k, rd_entry, rd_valid, rd_last, k, (k == 8));
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (state !== S_IDLE) begin n_fail++; $display("FAIL trig_idle state=%0d exp=0", state); end
  endtask

  task automatic test_halt_post0;
    do_arm(1'b1, '0);
    for (int i = 1; i <= 2; i++) begin
      cap_valid = 1'b1; cap_entry = ENTRY_W'(i); cap_halt = (i == 2);
      tick();
    end
    cap_valid = 1'b0; cap_halt = 1'b0;
    n_checks++;
    if (state !== S_DONE || count !== CNT_W'(2) || triggered !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_done state=%0d count=%0d trig=%b exp state=3 count=2 trig=1", state, count, triggered);
    end
    wait_rd("halt");
    rd_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      n_checks++;
      if (rd_entry !== ENTRY_W'(k) || rd_last !== (k == 2)) begin
        n_fail++;
        $display("FAIL halt_read%0d entry=%0h last=%b exp entry=%0h last=%b", k, rd_entry, rd_last, k, (k == 2));
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (state !== S_IDLE || count !== '0) begin
      n_fail++; $display("FAIL halt_idle state=%0d count=%0d exp 0/0", state, count);
    end
  endtask

  task automatic test_backpressure;
    do_arm(1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      cap_valid = 1'b1; cap_entry = ENTRY_W'(8'h11 + i);
      tick();
    end
    cap_valid = 1'b0;
    wait_rd("bp");
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_entry !== ENTRY_W'(8'h11) || count !== CNT_W'(4)) begin
        n_fail++;
        $display("FAIL bp_hold%0d valid=%b entry=%0h count=%0d exp valid=1 entry=11 count=4", c, rd_valid, rd_entry, count);
      end
      tick();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_entry !== ENTRY_W'(8'h11 + k)) begin
        n_fail++; $display("FAIL bp_pop%0d valid=%b entry=%0h exp valid=1 entry=%0h", k, rd_valid, rd_entry, 8'h11 + k);
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (state !== S_IDLE || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle state=%0d rdv=%b exp 0/0", state, rd_valid);
    end
  endtask

  task automatic test_stop_rearm;
    do_arm(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cap_valid = 1'b1; cap_entry = ENTRY_W'(8'hA1 + i); stop = (i == 2);
      tick();
    end
    cap_valid = 1'b0; stop = 1'b0;
    n_checks++;
    if (state !== S_DONE || count !== CNT_W'(3)) begin
      n_fail++; $display("FAIL stop_done state=%0d count=%0d exp state=3 count=3", state, count);
    end
    wait_rd("stop");
    n_checks++;
    if (rd_entry !== ENTRY_W'(8'hA1) || rd_last !== 1'b0) begin
      n_fail++; $display("FAIL stop_head entry=%0h last=%b exp entry=a1 last=0", rd_entry, rd_last);
    end
    do_arm(1'b0, '0);
    n_checks++;
    if (state !== S_ARMED || count !== '0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rearm state=%0d count=%0d rdv=%b exp 1/0/0", state, count, rd_valid);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick();
    n_checks++;
    if (state !== S_IDLE || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL stop_empty state=%0d rdv=%b exp 0/0", state, rd_valid);
    end
  endtask

  task automatic test_async_reset;
    do_arm(1'b1, CNT_W'(7));
    for (int i = 1; i <= 2; i++) begin
      cap_valid = 1'b1; cap_entry = ENTRY_W'(i); cap_halt = (i == 2);
      tick();
    end
    cap_halt = 1'b0; cap_entry = ENTRY_W'(3);
    n_checks++;
    if (state !== S_POST || triggered !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre state=%0d trig=%b exp state=2 trig=1", state, triggered);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (state !== S_IDLE || count !== '0 || triggered !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_outputs state=%0d count=%0d trig=%b rdv=%b last=%b exp 0/0/0/0/0",
               state, count, triggered, rd_valid, rd_last);
    end
    cap_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (state !== S_IDLE || count !== '0) begin
      n_fail++; $display("FAIL areset_after state=%0d count=%0d exp 0/0", state, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_trig_pc();
    test_halt_post0();
    test_backpressure();
    test_stop_rearm();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
